instr_encoder: RTL

Program loader that is the encoding counterpart of the MIPS-lite main control decoder. It accepts symbolic instruction requests over a valid/ready handshake and packs each into a 32-bit MIPS-lite word, using the same opcode map the control decoder uses. It writes the words sequentially into instruction memory through a write/ack interface. It sits between the bench or boot source and the instruction memory of the single-cycle core.

---
 rtl/instr_encoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Program loader. Packs symbolic instruction requests into 32-bit
//            MIPS-lite words (same opcode map as the main control decoder) and
//            writes them sequentially into instruction memory via write/ack.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          MEM_DEPTH = 64,
    parameter int unsigned          CNT_W     = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [4:0]          req_rs,
    input  logic [4:0]          req_rt,
    input  logic [4:0]          req_rd,
    input  logic [15:0]         req_imm,
    input  logic [25:0]         req_target,
    output logic                im_we,
    output logic [ADDR_W-1:0]   im_addr,
    output logic [31:0]         im_wdata,
    input  logic                im_ack,
    output logic [CNT_W-1:0]    word_count,
    output logic                full,
    output logic                err_illegal
);

    // Loader states
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;
    localparam logic [1:0] c_ST_ERR   = 2'd3;

    // Symbolic request operations
    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_SLT  = 4'd4;
    localparam logic [3:0] c_OP_SLLV = 4'd5;
    localparam logic [3:0] c_OP_LW   = 4'd6;
    localparam logic [3:0] c_OP_SW   = 4'd7;
    localparam logic [3:0] c_OP_BEQ  = 4'd8;
    localparam logic [3:0] c_OP_NORI = 4'd9;
    localparam logic [3:0] c_OP_JAL  = 4'd10;
    localparam logic [3:0] c_OP_JSP  = 4'd11;
    localparam logic [3:0] c_OP_BGTZ = 4'd12;

    // Machine opcodes (match the control decoder's map)
    localparam logic [5:0] c_OPC_RTYPE = 6'b000000;
    localparam logic [5:0] c_OPC_LW    = 6'b100011;
    localparam logic [5:0] c_OPC_SW    = 6'b101011;
    localparam logic [5:0] c_OPC_BEQ   = 6'b000100;
    localparam logic [5:0] c_OPC_NORI  = 6'b001101;
    localparam logic [5:0] c_OPC_JAL   = 6'b000011;
    localparam logic [5:0] c_OPC_JSP   = 6'b010010;
    localparam logic [5:0] c_OPC_BGTZ  = 6'b100110;

    // R-format function codes
    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;
    localparam logic [5:0] c_FN_SLLV = 6'b000100;

    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(MEM_DEPTH);

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_count;

    logic [31:0]        w_enc;
    logic               w_illegal;
    logic [CNT_W-1:0]   w_count_inc;

    assign w_count_inc = r_count + CNT_W'(1);

    // Encode the current request; only the fields of the selected format are used
    always_comb begin
        w_enc     = '0;
        w_illegal = 1'b0;
        case (req_op)
            c_OP_ADD:  w_enc = {c_OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, c_FN_ADD};
            c_OP_SUB:  w_enc = {c_OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, c_FN_SUB};
            c_OP_AND:  w_enc = {c_OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, c_FN_AND};
            c_OP_OR:   w_enc = {c_OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, c_FN_OR};
            c_OP_SLT:  w_enc = {c_OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, c_FN_SLT};
            c_OP_SLLV: w_enc = {c_OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, c_FN_SLLV};
            c_OP_LW:   w_enc = {c_OPC_LW,   req_rs, req_rt, req_imm};
            c_OP_SW:   w_enc = {c_OPC_SW,   req_rs, req_rt, req_imm};
            c_OP_BEQ:  w_enc = {c_OPC_BEQ,  req_rs, req_rt, req_imm};
            c_OP_NORI: w_enc = {c_OPC_NORI, req_rs, req_rt, req_imm};
            c_OP_JAL:  w_enc = {c_OPC_JAL,  req_target};
            c_OP_JSP:  w_enc = {c_OPC_JSP,  26'b0};
            c_OP_BGTZ: w_enc = {c_OPC_BGTZ, req_rs, 5'b0, req_imm};
            default:   w_illegal = 1'b1;
        endcase
    end

    // Loader FSM with address/count bookkeeping; start overrides every other event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_addr  <= BASE_ADDR;
            r_wdata <= '0;
            r_count <= '0;
        end else if (start) begin
            // An in-flight write is abandoned: no address advance, no count
            r_state <= c_ST_IDLE;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        if (w_illegal) begin
                            r_state <= c_ST_ERR;
                        end else begin
                            r_wdata <= w_enc;
                            r_state <= c_ST_WRITE;
                        end
                    end
                end
                c_ST_WRITE: begin
                    if (im_ack) begin
                        r_addr  <= r_addr + ADDR_W'(4);
                        r_count <= w_count_inc;
                        r_state <= (w_count_inc == c_DEPTH) ? c_ST_FULL : c_ST_IDLE;
                    end
                end
                c_ST_FULL: r_state <= c_ST_FULL;
                c_ST_ERR:  r_state <= c_ST_ERR;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so they drop with reset immediately
    assign req_ready   = rst_n && (r_state == c_ST_IDLE);
    assign im_we       = (r_state == c_ST_WRITE);
    assign full        = (r_state == c_ST_FULL);
    assign err_illegal = (r_state == c_ST_ERR);
    assign im_addr     = r_addr;
    assign im_wdata    = r_wdata;
    assign word_count  = r_count;

endmodule
`default_nettype wire
